hmac_stream_arbiter: RTL

- Shares one HMAC/metadata-check pipeline between N_SRC AXI4-Stream sources.
- Arbitrates round-robin at transfer granularity: a grant is held from the first beat to the tlast beat.
- Truncates and poisons oversize transfers so the downstream HMAC check rejects them.
- Sits upstream of the metadata checker and HMAC unit. Keeps per-source status counters.

---
 rtl/hmac_stream_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hmac_stream_arbiter.sv
// Round-robin, transfer-granular arbiter feeding one HMAC/metadata-check pipeline from N_SRC AXI4-Stream sources.
// Zero-latency passthrough once granted, one bubble per arbitration; m_axis_tready stalls only the granted source.
module hmac_stream_arbiter #(
    parameter  int N_SRC     = 4,
    parameter  int MAX_BEATS = 64,
    parameter  int CNT_W     = 32,
    localparam int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_areset,
    input  logic [N_SRC-1:0]         src_enable,
    input  logic [N_SRC-1:0]         s_axis_tvalid,
    output logic [N_SRC-1:0]         s_axis_tready,
    input  logic [N_SRC*512-1:0]     s_axis_tdata,
    input  logic [N_SRC*64-1:0]      s_axis_tkeep,
    input  logic [N_SRC*6-1:0]       s_axis_tid,
    input  logic [N_SRC-1:0]         s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [511:0]             m_axis_tdata,
    output logic [63:0]              m_axis_tkeep,
    output logic [5:0]               m_axis_tid,
    output logic                     m_axis_tlast,
    output logic [SRC_W-1:0]         m_axis_tdest,
    output logic [N_SRC-1:0]         stat_oversize,
    output logic [N_SRC*CNT_W-1:0]   stat_xfer_cnt
);

    localparam int BEAT_W = $clog2(MAX_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    logic [SRC_W-1:0]   grant_q;
    logic [SRC_W-1:0]   last_grant_q;
    logic [BEAT_W-1:0]  beat_cnt_q;
    logic [N_SRC-1:0]   oversize_q;
    logic [CNT_W-1:0]   xfer_cnt_q [N_SRC];

    logic [N_SRC-1:0]   cand;
    logic               arb_vld;
    logic [SRC_W-1:0]   grant_d;
    int                 scan_idx;

    logic [31:0]        gidx;
    logic               sel_tvalid;
    logic               sel_tlast;
    logic [511:0]       sel_tdata;
    logic [63:0]        sel_tkeep;
    logic [5:0]         sel_tid;

    logic               beat_at_limit;
    logic               xfer_acc;
    logic               drain_acc;
    logic               oversize_beat;

    // Later writes win, so scanning from the farthest offset down leaves the
    // nearest candidate after last_grant_q as the winner.
    always_comb begin
        cand     = s_axis_tvalid & src_enable;
        arb_vld  = 1'b0;
        grant_d  = '0;
        scan_idx = 0;
        for (int k = N_SRC; k >= 1; k--) begin
            scan_idx = (int'(last_grant_q) + k) % N_SRC;
            if (cand[scan_idx]) begin
                arb_vld = 1'b1;
                grant_d = SRC_W'(scan_idx);
            end
        end
    end

    assign gidx = 32'(grant_q);

    always_comb begin
        sel_tvalid = s_axis_tvalid[gidx];
        sel_tlast  = s_axis_tlast[gidx];
        sel_tdata  = s_axis_tdata[gidx*512 +: 512];
        sel_tkeep  = s_axis_tkeep[gidx*64 +: 64];
        sel_tid    = s_axis_tid[gidx*6 +: 6];
    end

    assign beat_at_limit = (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));
    assign xfer_acc      = (state_q == ST_XFER) && sel_tvalid && m_axis_tready;
    assign drain_acc     = (state_q == ST_DRAIN) && sel_tvalid;
    // The final permitted beat of a transfer without tlast is forced to a
    // poisoned, terminated beat so the HMAC check downstream rejects it.
    assign oversize_beat = (state_q == ST_XFER) && beat_at_limit && !sel_tlast;

    always_comb begin
        m_axis_tvalid = (state_q == ST_XFER) && sel_tvalid;
        m_axis_tdata  = oversize_beat ? '1 : sel_tdata;
        m_axis_tkeep  = oversize_beat ? '1 : sel_tkeep;
        m_axis_tid    = sel_tid;
        m_axis_tlast  = sel_tlast || oversize_beat;
        m_axis_tdest  = grant_q;
    end

    always_comb begin
        s_axis_tready = '0;
        if (state_q == ST_XFER) begin
            s_axis_tready[gidx] = m_axis_tready;
        end else if (state_q == ST_DRAIN) begin
            s_axis_tready[gidx] = 1'b1;
        end
    end

    assign stat_oversize = oversize_q;

    always_comb begin
        stat_xfer_cnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            stat_xfer_cnt[i*CNT_W +: CNT_W] = xfer_cnt_q[i];
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(N_SRC - 1);
            beat_cnt_q   <= '0;
            oversize_q   <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                xfer_cnt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant_q    <= grant_d;
                        beat_cnt_q <= '0;
                        state_q    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (xfer_acc) begin
                        beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                        if (sel_tlast) begin
                            xfer_cnt_q[gidx] <= xfer_cnt_q[gidx] + CNT_W'(1);
                            last_grant_q     <= grant_q;
                            state_q          <= ST_IDLE;
                        end else if (beat_at_limit) begin
                            oversize_q[gidx] <= 1'b1;
                            last_grant_q     <= grant_q;
                            state_q          <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_acc && sel_tlast) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
